// File: rtl/usb_rx_frontend.sv
// USB receive front end: pin synchroniser, line-state decode and glitch filter,
// 4x-oversampling DPLL producing raw J/K symbols, and end-of-packet detection.
module usb_rx_frontend (
  input  logic       clk,
  input  logic       reset_ni,
  input  logic       usb_full_speed,
  input  logic       dp_i,
  input  logic       dm_i,
  output logic [1:0] line_state_o,
  output logic       se0,
  output logic       rx_strobe_o,
  output logic       rx_bit_o,
  output logic       eop_o
);

  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_J   = 2'b01,
    LS_K   = 2'b10,
    LS_SE1 = 2'b11
  } line_t;

  logic       dp_s1, dp_s2, dm_s1, dm_s2;
  line_t      raw, raw_next;
  line_t      ls, ls_next, ls_prev;
  logic       ls_change;
  logic [1:0] phase, phase_next;
  logic [2:0] se0_cnt, se0_cnt_next;
  logic       strobe_next, bit_next, eop_next;

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      dp_s1       <= 1'b0;
      dp_s2       <= 1'b0;
      dm_s1       <= 1'b0;
      dm_s2       <= 1'b0;
      raw         <= LS_SE0;
      ls          <= LS_SE0;
      ls_prev     <= LS_SE0;
      phase       <= '0;
      se0_cnt     <= '0;
      rx_strobe_o <= 1'b0;
      rx_bit_o    <= 1'b0;
      eop_o       <= 1'b0;
    end else begin
      dp_s1       <= dp_i;
      dp_s2       <= dp_s1;
      dm_s1       <= dm_i;
      dm_s2       <= dm_s1;
      raw         <= raw_next;
      ls          <= ls_next;
      ls_prev     <= ls;
      phase       <= phase_next;
      se0_cnt     <= se0_cnt_next;
      rx_strobe_o <= strobe_next;
      rx_bit_o    <= bit_next;
      eop_o       <= eop_next;
    end
  end

  always_comb begin
    // Low speed swaps J/K; SE0/SE1 encode identically in either order.
    raw_next = usb_full_speed ? line_t'({dm_s2, dp_s2}) : line_t'({dp_s2, dm_s2});

    // Filter accepts raw once the sample about to replace it agrees with it.
    ls_next   = (raw_next == raw) ? raw : ls;
    ls_change = (ls_next != ls);

    phase_next  = ls_change ? 2'd0 : phase + 2'd1;
    strobe_next = !ls_change && (phase == 2'd1) && ((ls == LS_J) || (ls == LS_K));
    bit_next    = strobe_next ? (ls == LS_J) : rx_bit_o;

    se0_cnt_next = '0;
    if (ls == LS_SE0) begin
      se0_cnt_next = (se0_cnt == 3'd7) ? se0_cnt : se0_cnt + 3'd1;
    end

    // ls_prev/se0_cnt still describe the SE0 run on the cycle J first appears.
    eop_next = (ls == LS_J) && (ls_prev == LS_SE0) && (se0_cnt >= 3'd4);
  end

  assign line_state_o = ls;
  assign se0          = (ls == LS_SE0);

endmodule
